// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo_pkg
//  Description : Shared types and defaults for the async FIFO read/write
//                side helpers (state encoding, default widths).
//  Revision    : 1.0  initial release
// ============================================================================
package async_fifo_pkg;

    localparam int DSIZE_DEF  = 8;
    localparam int IDLE_R_DEF = 3;

    // Read-side drain controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        GAP   = 2'd2
    } rd_state_e;

    // Gap counter width: enough bits to hold idle_r, never less than one bit
    function automatic int gap_width(input int idle_r);
        return (idle_r > 0) ? $clog2(idle_r + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_out_reg
//  Description : One-entry valid/ready output register. A load replaces the
//                held word (the caller only loads when the slot is free or
//                being accepted in the same cycle); an accept without a load
//                empties the slot.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_out_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid
);

    logic [DW-1:0] r_data;
    logic          r_valid;

    // Hold / load / drain the single output slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/async_fifo_rd_drain.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo_rd_drain
//  Description : Read-side consumer for the async FIFO read port. Pops words
//                with a programmable idle gap, forwards them through a
//                one-entry valid/ready register and keeps a word count and
//                a running XOR checksum. Single clock domain (rclk).
//  Revision    : 1.0  initial release
// ============================================================================
module async_fifo_rd_drain
    import async_fifo_pkg::*;
#(
    parameter int DSIZE  = DSIZE_DEF,
    parameter int IDLE_R = IDLE_R_DEF,
    parameter int CNT_W  = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             enable,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_count,
    output logic [DSIZE-1:0] rd_xsum,
    output logic             busy
);

    localparam int               GAP_W      = gap_width(IDLE_R);
    localparam logic [GAP_W-1:0] c_GAP_LOAD = (IDLE_R > 0) ? GAP_W'(IDLE_R - 1) : '0;

    rd_state_e        r_state;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0] r_count;
    logic [DSIZE-1:0] r_xsum;
    logic             w_pop;

    // Pop only from a non-empty FIFO, when the output slot can take the word,
    // and never while reset is asserted
    assign w_pop = (r_state == FETCH) && !rempty && enable
                && (!m_valid || m_ready) && !rrst;

    // Drain state machine with post-pop idle gap
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (w_pop) begin
                        if (IDLE_R > 0) begin
                            r_state   <= GAP;
                            r_gap_cnt <= c_GAP_LOAD;
                        end
                    end else if (!enable) begin
                        r_state <= IDLE;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= FETCH;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Popped-word statistics: wrapping count and XOR checksum
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_count <= '0;
            r_xsum  <= '0;
        end else if (w_pop) begin
            r_count <= r_count + CNT_W'(1);
            r_xsum  <= r_xsum ^ rdata;
        end
    end

    fifo_out_reg #(
        .DW (DSIZE)
    ) u_out_reg (
        .clk     (rclk),
        .rst     (rrst),
        .i_load  (w_pop),
        .i_data  (rdata),
        .i_ready (m_ready),
        .o_data  (m_data),
        .o_valid (m_valid)
    );

    assign rinc     = w_pop;
    assign rd_count = r_count;
    assign rd_xsum  = r_xsum;
    assign busy     = (r_state != IDLE) || m_valid;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_rd_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_async_fifo_rd_drain
//  Description : Directed bench for async_fifo_rd_drain. Three instances share
//                one FIFO model: A (IDLE_R=3), B (IDLE_R=0), C (IDLE_R=0,
//                CNT_W=4). Only one instance is enabled at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_async_fifo_rd_drain;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       m_ready;
    logic       en_a, en_b, en_c;
    logic       rempty;
    logic [7:0] rdata;

    logic        rinc_a, rinc_b, rinc_c;
    logic [7:0]  m_data_a, m_data_b, m_data_c;
    logic        m_valid_a, m_valid_b, m_valid_c;
    logic [15:0] rd_count_a, rd_count_b;
    logic [3:0]  rd_count_c;
    logic [7:0]  rd_xsum_a, rd_xsum_b, rd_xsum_c;
    logic        busy_a, busy_b, busy_c;

    always #5 rclk = ~rclk;

    // FIFO model: bench writes wr_mem/wr_ptr, monitor advances rd_ptr on pops
    logic [7:0] wr_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = wr_mem[rd_ptr[7:0]];

    async_fifo_rd_drain #(.DSIZE(8), .IDLE_R(3), .CNT_W(16)) u_dut_a (
        .rclk(rclk), .rrst(rrst), .enable(en_a), .rempty(rempty), .rdata(rdata),
        .rinc(rinc_a), .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready),
        .rd_count(rd_count_a), .rd_xsum(rd_xsum_a), .busy(busy_a)
    );

    async_fifo_rd_drain #(.DSIZE(8), .IDLE_R(0), .CNT_W(16)) u_dut_b (
        .rclk(rclk), .rrst(rrst), .enable(en_b), .rempty(rempty), .rdata(rdata),
        .rinc(rinc_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready),
        .rd_count(rd_count_b), .rd_xsum(rd_xsum_b), .busy(busy_b)
    );

    async_fifo_rd_drain #(.DSIZE(8), .IDLE_R(0), .CNT_W(4)) u_dut_c (
        .rclk(rclk), .rrst(rrst), .enable(en_c), .rempty(rempty), .rdata(rdata),
        .rinc(rinc_c), .m_data(m_data_c), .m_valid(m_valid_c), .m_ready(m_ready),
        .rd_count(rd_count_c), .rd_xsum(rd_xsum_c), .busy(busy_c)
    );

    // Monitor: logs pops and accepted outputs, tracks run lengths
    logic [7:0] pop_a[$], pop_b[$], pop_c[$];
    logic [7:0] out_a[$], out_b[$], out_c[$];
    int         cyc_a[$];
    int         cyc = 0;
    int         illegal = 0;
    int         val_cyc_a = 0;
    int         run_rinc_b = 0, max_rinc_b = 0;
    int         run_val_b = 0, max_val_b = 0;

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if ((rinc_a || rinc_b || rinc_c) && rempty) illegal <= illegal + 1;
        if (rinc_a) begin pop_a.push_back(rdata); cyc_a.push_back(cyc); end
        if (rinc_b) pop_b.push_back(rdata);
        if (rinc_c) pop_c.push_back(rdata);
        if ((rinc_a || rinc_b || rinc_c) && !rempty) rd_ptr <= rd_ptr + 1;
        if (m_valid_a && m_ready) out_a.push_back(m_data_a);
        if (m_valid_b && m_ready) out_b.push_back(m_data_b);
        if (m_valid_c && m_ready) out_c.push_back(m_data_c);
        if (m_valid_a) val_cyc_a <= val_cyc_a + 1;
        run_rinc_b <= rinc_b ? run_rinc_b + 1 : 0;
        if (rinc_b && (run_rinc_b + 1 > max_rinc_b)) max_rinc_b <= run_rinc_b + 1;
        run_val_b <= m_valid_b ? run_val_b + 1 : 0;
        if (m_valid_b && (run_val_b + 1 > max_val_b)) max_val_b <= run_val_b + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge rclk);
        #2;
    endtask

    task automatic push(input logic [7:0] w);
        wr_mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    initial begin
        logic [7:0]  exp1 [4];
        logic [7:0]  exp_w;
        logic [7:0]  xs;
        logic [31:0] got;
        int          base, pbase, vbase;

        exp1    = '{8'h11, 8'h22, 8'h33, 8'h44};
        rrst    = 1'b1;
        en_a    = 1'b0;
        en_b    = 1'b0;
        en_c    = 1'b0;
        m_ready = 1'b1;
        wait_cyc(2);

        // Reset state
        check("rst_rinc",    {31'd0, rinc_a},    32'd0);
        check("rst_m_valid", {31'd0, m_valid_a}, 32'd0);
        check("rst_m_data",  {24'd0, m_data_a},  32'd0);
        check("rst_count",   {16'd0, rd_count_a}, 32'd0);
        check("rst_xsum",    {24'd0, rd_xsum_a}, 32'd0);
        check("rst_busy",    {31'd0, busy_a},    32'd0);
        rrst = 1'b0;

        // Basic drain with a 3-cycle idle gap
        base = out_a.size();
        pbase = cyc_a.size();
        en_a = 1'b1;
        for (int i = 0; i < 4; i++) push(exp1[i]);
        wait_cyc(20);
        check("drain_pops", cyc_a.size() - pbase, 32'd4);
        for (int i = 1; i < 4; i++) begin
            got = (pbase + i < cyc_a.size()) ? cyc_a[pbase + i] - cyc_a[pbase + i - 1] : 32'hDEADBEEF;
            check("drain_spacing", got, 32'd4);
        end
        for (int i = 0; i < 4; i++) begin
            got = (base + i < out_a.size()) ? {24'd0, out_a[base + i]} : 32'hDEADBEEF;
            check("drain_data", got, {24'd0, exp1[i]});
        end
        check("drain_count", {16'd0, rd_count_a}, 32'd4);
        check("drain_xsum",  {24'd0, rd_xsum_a},  32'h44);
        en_a = 1'b0;
        wait_cyc(5);

        // Back-to-back pops with no gap
        base = out_b.size();
        en_b = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(i));
        wait_cyc(15);
        check("b2b_rinc_run",  max_rinc_b, 32'd8);
        check("b2b_valid_run", max_val_b,  32'd8);
        check("b2b_count", {16'd0, rd_count_b}, 32'd8);
        check("b2b_xsum",  {24'd0, rd_xsum_b},  32'h00);
        for (int i = 0; i < 8; i++) begin
            got = (base + i < out_b.size()) ? {24'd0, out_b[base + i]} : 32'hDEADBEEF;
            check("b2b_data", got, i);
        end

        // Backpressure: hold 0xA5 for 10 cycles, then release
        base = out_b.size();
        m_ready = 1'b0;
        push(8'hA5);
        push(8'hB6);
        wait_cyc(1);
        for (int i = 0; i < 10; i++) begin
            check("bp_m_data",  {24'd0, m_data_b},  32'hA5);
            check("bp_m_valid", {31'd0, m_valid_b}, 32'd1);
            check("bp_rinc",    {31'd0, rinc_b},    32'd0);
            wait_cyc(1);
        end
        m_ready = 1'b1;
        wait_cyc(5);
        check("bp_out_n", out_b.size() - base, 32'd2);
        got = (base < out_b.size()) ? {24'd0, out_b[base]} : 32'hDEADBEEF;
        check("bp_out0", got, 32'hA5);
        got = (base + 1 < out_b.size()) ? {24'd0, out_b[base + 1]} : 32'hDEADBEEF;
        check("bp_out1", got, 32'hB6);
        check("bp_count", {16'd0, rd_count_b}, 32'd10);
        check("bp_xsum",  {24'd0, rd_xsum_b},  32'h13);
        en_b = 1'b0;
        wait_cyc(3);

        // Empty gating
        rrst = 1'b1;
        wait_cyc(1);
        rrst = 1'b0;
        pbase = pop_a.size();
        vbase = val_cyc_a;
        en_a = 1'b1;
        wait_cyc(20);
        check("empty_pops",  pop_a.size() - pbase, 32'd0);
        check("empty_valid", val_cyc_a - vbase,    32'd0);
        base = out_a.size();
        push(8'h5A);
        wait_cyc(10);
        check("empty_one_pop", pop_a.size() - pbase, 32'd1);
        check("empty_count", {16'd0, rd_count_a}, 32'd1);
        check("empty_xsum",  {24'd0, rd_xsum_a},  32'h5A);
        got = (base < out_a.size()) ? {24'd0, out_a[base]} : 32'hDEADBEEF;
        check("empty_data", got, 32'h5A);

        // Reset in the middle of a gap with a held word
        m_ready = 1'b0;
        push(8'h77);
        push(8'h88);
        wait_cyc(1);
        check("mid_valid", {31'd0, m_valid_a}, 32'd1);
        check("mid_data",  {24'd0, m_data_a},  32'h77);
        rrst = 1'b1;
        wait_cyc(1);
        check("mid_rst_valid", {31'd0, m_valid_a}, 32'd0);
        check("mid_rst_count", {16'd0, rd_count_a}, 32'd0);
        check("mid_rst_xsum",  {24'd0, rd_xsum_a},  32'd0);
        check("mid_rst_busy",  {31'd0, busy_a},     32'd0);
        check("mid_rst_rinc",  {31'd0, rinc_a},     32'd0);
        base = out_a.size();
        rrst = 1'b0;
        m_ready = 1'b1;
        wait_cyc(10);
        check("mid_resume_count", {16'd0, rd_count_a}, 32'd1);
        check("mid_resume_xsum",  {24'd0, rd_xsum_a},  32'h88);
        check("mid_resume_n", out_a.size() - base, 32'd1);
        got = (base < out_a.size()) ? {24'd0, out_a[base]} : 32'hDEADBEEF;
        check("mid_resume_data", got, 32'h88);
        en_a = 1'b0;
        wait_cyc(6);

        // Counter wrap with a 4-bit count, stalls mixed in
        base = out_c.size();
        pbase = pop_c.size();
        xs = 8'h00;
        en_c = 1'b1;
        for (int i = 0; i < 17; i++) begin
            exp_w = 8'(i * 29 + 3);
            xs = xs ^ exp_w;
            push(exp_w);
        end
        for (int k = 0; k < 40; k++) begin
            m_ready = (k % 3 != 2);
            wait_cyc(1);
        end
        m_ready = 1'b1;
        wait_cyc(5);
        check("wrap_count", {28'd0, rd_count_c}, 32'd1);
        check("wrap_xsum",  {24'd0, rd_xsum_c},  {24'd0, xs});
        check("wrap_pops",  pop_c.size() - pbase, 32'd17);
        check("wrap_outs",  out_c.size() - base,  32'd17);
        for (int i = 0; i < 17; i++) begin
            exp_w = 8'(i * 29 + 3);
            got = (pbase + i < pop_c.size()) ? {24'd0, pop_c[pbase + i]} : 32'hDEADBEEF;
            check("wrap_rdata_seq", got, {24'd0, exp_w});
            got = (base + i < out_c.size()) ? {24'd0, out_c[base + i]} : 32'hDEADBEEF;
            check("wrap_mdata_seq", got, {24'd0, exp_w});
        end

        check("no_empty_pop", illegal, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
